// File: rtl/ysyx_22040750_mem_arbiter.sv
// ysyx_22040750_mem_arbiter: shares one memory port between instruction fetch and the LSU, one transaction in flight.
module ysyx_22040750_mem_arbiter (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_if_req_valid,
  input  logic [31:0] I_if_addr,
  input  logic        I_if_flush,
  output logic        O_if_req_ready,
  output logic        O_if_resp_valid,
  output logic [31:0] O_if_inst,
  input  logic        I_lsu_req_valid,
  input  logic [31:0] I_lsu_addr,
  input  logic        I_lsu_wen,
  input  logic [63:0] I_lsu_wdata,
  input  logic [7:0]  I_lsu_wmask,
  output logic        O_lsu_req_ready,
  output logic        O_lsu_resp_valid,
  output logic [63:0] O_lsu_rdata,
  output logic        O_mem_req_valid,
  input  logic        I_mem_req_ready,
  output logic [31:0] O_mem_addr,
  output logic        O_mem_wen,
  output logic [63:0] O_mem_wdata,
  output logic [7:0]  O_mem_wmask,
  input  logic        I_mem_resp_valid,
  input  logic [63:0] I_mem_rdata
);
  typedef enum logic [2:0] {IDLE, REQ_IF, WAIT_IF, REQ_LSU, WAIT_LSU} state_t;
  state_t state, state_n;
  logic last_lsu, drop, drop_n, sel_hi, if_ok, grant_if, grant_lsu;
  assign if_ok     = I_if_req_valid && !I_if_flush;
  assign grant_lsu = (state == IDLE) && I_lsu_req_valid && (!if_ok || !last_lsu);
  assign grant_if  = (state == IDLE) && if_ok && (!I_lsu_req_valid || last_lsu);
  assign O_if_req_ready   = grant_if;
  assign O_lsu_req_ready  = grant_lsu;
  assign O_mem_req_valid  = (state == REQ_IF) || (state == REQ_LSU);
  // a flush arriving in the response cycle itself must still suppress the instruction
  assign O_if_resp_valid  = (state == WAIT_IF) && I_mem_resp_valid && !drop && !I_if_flush;
  assign O_lsu_resp_valid = (state == WAIT_LSU) && I_mem_resp_valid;
  assign O_if_inst        = O_if_resp_valid ? (sel_hi ? I_mem_rdata[63:32] : I_mem_rdata[31:0]) : 32'h0;
  assign O_lsu_rdata      = O_lsu_resp_valid ? I_mem_rdata : 64'h0;
  always_comb begin
    state_n = state;
    drop_n  = 1'b0;
    case (state)
      IDLE: state_n = grant_lsu ? REQ_LSU : grant_if ? REQ_IF : IDLE;
      REQ_IF: begin
        state_n = I_mem_req_ready ? WAIT_IF : I_if_flush ? IDLE : REQ_IF;
        drop_n  = I_mem_req_ready && I_if_flush;
      end
      WAIT_IF: begin
        state_n = I_mem_resp_valid ? IDLE : WAIT_IF;
        drop_n  = !I_mem_resp_valid && (drop || I_if_flush);
      end
      REQ_LSU:  state_n = I_mem_req_ready ? WAIT_LSU : REQ_LSU;
      WAIT_LSU: state_n = I_mem_resp_valid ? IDLE : WAIT_LSU;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      state       <= IDLE;
      last_lsu    <= 1'b0;
      drop        <= 1'b0;
      sel_hi      <= 1'b0;
      O_mem_addr  <= 32'h0;
      O_mem_wen   <= 1'b0;
      O_mem_wdata <= 64'h0;
      O_mem_wmask <= 8'h0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      if (grant_lsu) begin
        last_lsu    <= 1'b1;
        sel_hi      <= I_lsu_addr[2];
        O_mem_addr  <= I_lsu_addr;
        O_mem_wen   <= I_lsu_wen;
        O_mem_wdata <= I_lsu_wdata;
        O_mem_wmask <= I_lsu_wmask;
      end else if (grant_if) begin
        last_lsu    <= 1'b0;
        sel_hi      <= I_if_addr[2];
        O_mem_addr  <= I_if_addr;
        O_mem_wen   <= 1'b0;
        O_mem_wdata <= 64'h0;
        O_mem_wmask <= 8'h0;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22040750_mem_arbiter.sv
// tb_ysyx_22040750_mem_arbiter: directed stimulus with a response scoreboard for the memory arbiter.
module tb_ysyx_22040750_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_valid = 0, if_flush = 0, if_ready, if_resp;
  logic [31:0] if_addr = 0, if_inst;
  logic        lsu_valid = 0, lsu_wen = 0, lsu_ready, lsu_resp;
  logic [31:0] lsu_addr = 0;
  logic [63:0] lsu_wdata = 0, lsu_rdata;
  logic [7:0]  lsu_wmask = 0;
  logic        mem_valid, mem_ready = 0, mem_wen, mem_resp = 0;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata = 0;
  logic [7:0]  mem_wmask;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic lsu; logic [63:0] d;} exp_t;
  exp_t exp_q[$];

  ysyx_22040750_mem_arbiter dut (
    .I_sys_clk(clk), .I_rst(rst),
    .I_if_req_valid(if_valid), .I_if_addr(if_addr), .I_if_flush(if_flush),
    .O_if_req_ready(if_ready), .O_if_resp_valid(if_resp), .O_if_inst(if_inst),
    .I_lsu_req_valid(lsu_valid), .I_lsu_addr(lsu_addr), .I_lsu_wen(lsu_wen),
    .I_lsu_wdata(lsu_wdata), .I_lsu_wmask(lsu_wmask),
    .O_lsu_req_ready(lsu_ready), .O_lsu_resp_valid(lsu_resp), .O_lsu_rdata(lsu_rdata),
    .O_mem_req_valid(mem_valid), .I_mem_req_ready(mem_ready), .O_mem_addr(mem_addr),
    .O_mem_wen(mem_wen), .O_mem_wdata(mem_wdata), .O_mem_wmask(mem_wmask),
    .I_mem_resp_valid(mem_resp), .I_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic l, input logic [63:0] d);
    exp_t e;
    e.lsu = l;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // drive from the REQ cycle through the response cycle, leaving the arbiter in IDLE
  task automatic mem_serve(input logic [63:0] d, input int stall);
    for (int i = 0; i < stall; i++) begin
      mem_ready = 0;
      cyc();
    end
    mem_ready = 1;
    cyc();
    mem_ready = 0;
    mem_resp = 1;
    mem_rdata = d;
    cyc();
    mem_resp = 0;
  endtask

  task automatic chk_mem(input string nm, input logic v, input logic [31:0] a, input logic w,
                         input logic [63:0] wd, input logic [7:0] m);
    @(negedge clk);
    chk({nm, ".valid"}, {63'h0, mem_valid}, {63'h0, v});
    chk({nm, ".addr"}, {32'h0, mem_addr}, {32'h0, a});
    chk({nm, ".wen"}, {63'h0, mem_wen}, {63'h0, w});
    chk({nm, ".wdata"}, mem_wdata, wd);
    chk({nm, ".wmask"}, {56'h0, mem_wmask}, {56'h0, m});
  endtask

  task automatic chk_ready(input string nm, input logic i, input logic l);
    @(negedge clk);
    chk({nm, ".if_ready"}, {63'h0, if_ready}, {63'h0, i});
    chk({nm, ".lsu_ready"}, {63'h0, lsu_ready}, {63'h0, l});
  endtask

  always @(negedge clk) begin
    if (!rst && (if_resp || lsu_resp)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got if=%b lsu=%b want none", if_resp, lsu_resp);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp.owner", {62'h0, lsu_resp, if_resp}, {62'h0, e.lsu, !e.lsu});
        chk("resp.data", e.lsu ? lsu_rdata : {32'h0, if_inst}, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc();
    chk_mem("reset.mem", 0, 0, 0, 0, 0);
    chk_ready("reset", 0, 0);
    chk("reset.resp", {62'h0, if_resp, lsu_resp}, 64'h0);
    cyc();
    rst = 0;
    // single IF fetch, upper word selected by addr[2]
    if_valid = 1; if_addr = 32'h8000_0004;
    chk_ready("t1.grant", 1, 0);
    push(0, 64'h1111_2222);
    cyc();
    if_valid = 0;
    chk_mem("t1.req", 1, 32'h8000_0004, 0, 0, 0);
    mem_serve(64'h1111_2222_3333_4444, 0);
    // tie after reset: LSU, then IF, then LSU
    if_valid = 1; if_addr = 32'h8000_0000;
    lsu_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    chk_ready("t2.tie1", 0, 1);
    push(1, 64'h0123_4567_89AB_CDEF);
    cyc();
    lsu_valid = 0;
    mem_serve(64'h0123_4567_89AB_CDEF, 0);
    lsu_valid = 1;
    chk_ready("t2.tie2", 1, 0);
    push(0, 64'hCCCC_DDDD);
    cyc();
    if_valid = 0;
    mem_serve(64'hAAAA_BBBB_CCCC_DDDD, 0);
    if_valid = 1;
    chk_ready("t2.tie3", 0, 1);
    push(1, 64'h5555_6666_7777_8888);
    cyc();
    if_valid = 0; lsu_valid = 0;
    mem_serve(64'h5555_6666_7777_8888, 0);
    // LSU write with three stall cycles: fields held stable throughout
    lsu_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D; lsu_wmask = 8'h0F;
    chk_ready("t3.grant", 0, 1);
    push(1, 64'h0);
    cyc();
    lsu_valid = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_addr = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      chk_mem("t3.hold", 1, 32'h8000_1000, 1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
      cyc();
    end
    mem_ready = 0; mem_resp = 1; mem_rdata = 64'h0;
    cyc();
    mem_resp = 0;
    // flush while waiting: response dropped, pending LSU read granted right after
    if_valid = 1; if_addr = 32'h8000_0008;
    chk_ready("t4.grant", 1, 0);
    cyc();
    if_valid = 0; mem_ready = 1;
    cyc();
    mem_ready = 0; if_flush = 1; lsu_valid = 1; lsu_addr = 32'h8000_3000;
    cyc();
    if_flush = 0; mem_resp = 1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    chk("t4.drop", {63'h0, if_resp}, 64'h0);
    chk("t4.no_accept", {63'h0, lsu_ready}, 64'h0);
    cyc();
    mem_resp = 0;
    chk_ready("t4.lsu", 0, 1);
    push(1, 64'h1234_0000_5678_0000);
    cyc();
    lsu_valid = 0;
    mem_serve(64'h1234_0000_5678_0000, 0);
    // flush in REQ_IF with memory not ready: request withdrawn
    if_valid = 1; if_addr = 32'h8000_000C;
    chk_ready("t5.grant", 1, 0);
    cyc();
    if_valid = 0; if_flush = 1;
    chk_mem("t5.req", 1, 32'h8000_000C, 0, 0, 0);
    cyc();
    if_flush = 0;
    chk_mem("t5.gone", 0, 32'h8000_000C, 0, 0, 0);
    mem_resp = 1; mem_rdata = 64'h9999_9999_9999_9999;
    cyc();
    mem_resp = 0;
    // async reset in WAIT_LSU, late response ignored, tie resolves to LSU again
    lsu_valid = 1; lsu_addr = 32'h8000_4000;
    chk_ready("t6.grant", 0, 1);
    cyc();
    lsu_valid = 0; mem_ready = 1;
    cyc();
    mem_ready = 0;
    #2 rst = 1;
    #1;
    chk_mem("t6.rst", 0, 0, 0, 0, 0);
    cyc();
    rst = 0; mem_resp = 1; mem_rdata = 64'h7777_7777_7777_7777;
    @(negedge clk);
    chk("t6.late", {62'h0, lsu_resp, if_resp}, 64'h0);
    cyc();
    mem_resp = 0;
    if_valid = 1; if_addr = 32'h8000_0010; lsu_valid = 1; lsu_addr = 32'h8000_5000;
    chk_ready("t6.tie", 0, 1);
    push(1, 64'h4242_4242_4242_4242);
    cyc();
    lsu_valid = 0; if_valid = 0;
    mem_serve(64'h4242_4242_4242_4242, 0);
    repeat (3) cyc();
    chk("sb.empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
